// File: rtl/pipe_scheduler.sv
// Pipe spawn scheduler: counts game ticks, offers a pipe spawn with a gap row
// derived from the LFSR every SPACING ticks, and tracks the accepted-spawn score.
module pipe_scheduler #(
  parameter int unsigned SPACING = 8,
  parameter int unsigned ROWS    = 16,
  parameter int unsigned GAP     = 4
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       tick,
  input  logic [3:0] rnd,
  input  logic       spawn_ready,
  output logic       spawn_valid,
  output logic [3:0] gap_top,
  output logic       lfsr_reset,
  output logic [7:0] pipe_count,
  output logic       overrun
);

  localparam int unsigned MAX_TOP   = ROWS - GAP;
  localparam logic [7:0]  LAST_TICK = 8'(SPACING - 1);
  localparam logic [3:0]  MID_TOP   = 4'(MAX_TOP / 2);
  localparam logic [3:0]  WRAP      = 4'(MAX_TOP + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    OFFER
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  tick_cnt_q, tick_cnt_d;
  logic        spawn_valid_q, spawn_valid_d;
  logic [3:0]  gap_top_q, gap_top_d;
  logic        lfsr_reset_q, lfsr_reset_d;
  logic [7:0]  pipe_count_q, pipe_count_d;
  logic        overrun_q, overrun_d;
  logic [3:0]  gap_map_c;
  logic        lockup_c;

  // Fold the LFSR value into the legal gap range; all-ones is the XNOR lockup state.
  always_comb begin
    lockup_c  = (rnd == 4'hF);
    gap_map_c = rnd;
    if (lockup_c) begin
      gap_map_c = MID_TOP;
    end else if (32'(rnd) > MAX_TOP) begin
      gap_map_c = rnd - WRAP;
    end
  end

  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    spawn_valid_d = spawn_valid_q;
    gap_top_d     = gap_top_q;
    lfsr_reset_d  = 1'b0;
    pipe_count_d  = pipe_count_q;
    overrun_d     = overrun_q;

    if (!enable) begin
      // Game over: keep score and overrun visible as the final result.
      state_d       = IDLE;
      spawn_valid_d = 1'b0;
      tick_cnt_d    = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = WAIT;
          tick_cnt_d   = 8'd0;
          pipe_count_d = 8'd0;
          overrun_d    = 1'b0;
        end
        WAIT: begin
          if (tick) begin
            if (tick_cnt_q >= LAST_TICK) begin
              tick_cnt_d    = 8'd0;
              gap_top_d     = gap_map_c;
              lfsr_reset_d  = lockup_c;
              spawn_valid_d = 1'b1;
              state_d       = OFFER;
            end else begin
              tick_cnt_d = tick_cnt_q + 8'd1;
            end
          end
        end
        OFFER: begin
          // Ticks are dropped while the renderer stalls; remember that it happened.
          if (tick) begin
            overrun_d = 1'b1;
          end
          if (spawn_ready) begin
            spawn_valid_d = 1'b0;
            state_d       = WAIT;
            if (pipe_count_q != 8'hFF) begin
              pipe_count_d = pipe_count_q + 8'd1;
            end
          end
        end
        default: begin
          state_d       = IDLE;
          spawn_valid_d = 1'b0;
          tick_cnt_d    = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      tick_cnt_q    <= 8'd0;
      spawn_valid_q <= 1'b0;
      gap_top_q     <= 4'd0;
      lfsr_reset_q  <= 1'b0;
      pipe_count_q  <= 8'd0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      spawn_valid_q <= spawn_valid_d;
      gap_top_q     <= gap_top_d;
      lfsr_reset_q  <= lfsr_reset_d;
      pipe_count_q  <= pipe_count_d;
      overrun_q     <= overrun_d;
    end
  end

  assign spawn_valid = spawn_valid_q;
  assign gap_top     = gap_top_q;
  assign lfsr_reset  = lfsr_reset_q;
  assign pipe_count  = pipe_count_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Bench for pipe_scheduler: directed scenarios plus random play, spawns checked
// through a scoreboard queue against a game-level model of the scheduler.
module tb_pipe_scheduler;

  localparam int SPACING = 8;
  localparam int ROWS    = 16;
  localparam int GAP     = 4;
  localparam int MAX_TOP = ROWS - GAP;

  logic       Clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] rnd = 4'd0;
  logic       spawn_ready = 1'b0;
  logic       spawn_valid;
  logic [3:0] gap_top;
  logic       lfsr_reset;
  logic [7:0] pipe_count;
  logic       overrun;

  pipe_scheduler #(.SPACING(SPACING), .ROWS(ROWS), .GAP(GAP)) dut (
    .Clock(Clock), .reset(reset), .enable(enable), .tick(tick), .rnd(rnd),
    .spawn_ready(spawn_ready), .spawn_valid(spawn_valid), .gap_top(gap_top),
    .lfsr_reset(lfsr_reset), .pipe_count(pipe_count), .overrun(overrun)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Game-level model: state expected right after the next rising edge.
  bit m_run   = 0;
  bit m_off   = 0;
  int m_ticks = 0;
  int m_score = 0;
  bit m_ovr   = 0;
  bit m_lfsr  = 0;
  int exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gap_of(input int r);
    if (r == 15) return MAX_TOP / 2;
    return r % (MAX_TOP + 1);
  endfunction

  task automatic model_step(input bit en, input bit tk, input bit rdy, input int r);
    m_lfsr = 0;
    if (!en) begin
      m_run = 0; m_off = 0; m_ticks = 0;
    end else if (!m_run) begin
      m_run = 1; m_ticks = 0; m_score = 0; m_ovr = 0;
    end else if (m_off) begin
      if (tk) m_ovr = 1;
      if (rdy) begin
        m_off = 0;
        if (m_score < 255) m_score++;
      end
    end else if (tk) begin
      m_ticks++;
      if (m_ticks == SPACING) begin
        m_ticks = 0;
        m_off   = 1;
        m_lfsr  = (r == 15);
        exp_q.push_back(gap_of(r));
      end
    end
  endtask

  task automatic cycle(input bit en, input bit tk, input bit rdy, input int r);
    @(negedge Clock);
    enable = en; tick = tk; spawn_ready = rdy; rnd = 4'(r);
    model_step(en, tk, rdy, r);
  endtask

  // One idle cycle then one tick cycle, n times.
  task automatic tick_run(input int n, input bit rdy, input int r);
    for (int i = 0; i < n; i++) begin
      cycle(1, 0, rdy, r);
      cycle(1, 1, rdy, r);
    end
  endtask

  task automatic do_reset();
    @(negedge Clock);
    #1;
    reset = 1'b1; enable = 1'b0; tick = 1'b0; spawn_ready = 1'b0;
    m_run = 0; m_off = 0; m_ticks = 0; m_score = 0; m_ovr = 0; m_lfsr = 0;
    #1;
    chk("rst_valid", int'(spawn_valid), 0);
    chk("rst_gap", int'(gap_top), 0);
    chk("rst_lfsr", int'(lfsr_reset), 0);
    chk("rst_count", int'(pipe_count), 0);
    chk("rst_overrun", int'(overrun), 0);
    @(negedge Clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic after_edge();
    @(posedge Clock);
    #2;
  endtask

  // Monitor: compares registered outputs each cycle and pops a spawn on each new offer.
  bit prev_valid = 0;
  int held_gap   = 0;
  always @(posedge Clock) begin
    #1;
    chk("spawn_valid", int'(spawn_valid), int'(m_off));
    chk("pipe_count", int'(pipe_count), m_score);
    chk("overrun", int'(overrun), int'(m_ovr));
    chk("lfsr_reset", int'(lfsr_reset), int'(m_lfsr));
    if (spawn_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_spawn", 1, 0);
      end else begin
        held_gap = exp_q.pop_front();
        chk("gap_top", int'(gap_top), held_gap);
      end
    end else if (spawn_valid) begin
      chk("gap_stable", int'(gap_top), held_gap);
    end
    prev_valid = spawn_valid;
  end

  initial begin
    int guard;
    do_reset();

    // Basic spawn with rnd=5, renderer always ready.
    cycle(1, 0, 1, 5);
    tick_run(SPACING, 1, 5);
    after_edge();
    chk("d_valid_up", int'(spawn_valid), 1);
    chk("d_gap5", int'(gap_top), 5);
    cycle(1, 0, 1, 5);
    after_edge();
    chk("d_valid_down", int'(spawn_valid), 0);
    chk("d_count1", int'(pipe_count), 1);

    // Wrapped value and lockup value.
    tick_run(SPACING, 1, 14);
    after_edge();
    chk("d_gap14", int'(gap_top), 1);
    chk("d_lfsr14", int'(lfsr_reset), 0);
    cycle(1, 0, 1, 3);
    tick_run(SPACING, 1, 15);
    after_edge();
    chk("d_gap15", int'(gap_top), 6);
    chk("d_lfsr15", int'(lfsr_reset), 1);
    cycle(1, 0, 1, 15);
    after_edge();
    chk("d_lfsr_once", int'(lfsr_reset), 0);

    // Stalled renderer with ticks lost during the offer.
    tick_run(SPACING, 0, 9);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, $urandom_range(0, 15));
    after_edge();
    chk("d_stall_valid", int'(spawn_valid), 1);
    chk("d_stall_gap", int'(gap_top), 9);
    chk("d_overrun", int'(overrun), 1);
    cycle(1, 0, 1, 2);
    after_edge();
    chk("d_count_stall", int'(pipe_count), 4);
    tick_run(SPACING, 1, 2);
    cycle(1, 0, 1, 2);

    // Random play.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 63) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) != 0, $urandom_range(0, 15));
    end

    // Saturation: tick every cycle, always ready.
    for (int i = 0; i < 2800; i++) cycle(1, 1, 1, $urandom_range(0, 15));
    after_edge();
    chk("d_saturate", int'(pipe_count), 255);

    // Enable dropped during an offer, then game restarted.
    guard = 0;
    while (!m_off && guard < 100) begin
      cycle(1, 1, 0, 7);
      guard++;
    end
    chk("offer_timeout", int'(m_off), 1);
    cycle(0, 1, 1, 7);
    after_edge();
    chk("d_drop_valid", int'(spawn_valid), 0);
    chk("d_drop_count", int'(pipe_count), 255);
    cycle(1, 0, 0, 7);
    after_edge();
    chk("d_reen_count", int'(pipe_count), 0);
    chk("d_reen_overrun", int'(overrun), 0);

    // Asynchronous reset while offering.
    tick_run(SPACING, 0, 11);
    cycle(1, 1, 0, 11);
    after_edge();
    chk("d_pre_rst_valid", int'(spawn_valid), 1);
    do_reset();
    cycle(0, 0, 0, 0);
    cycle(0, 1, 1, 0);
    after_edge();
    chk("d_idle_hold", int'(spawn_valid), 0);

    repeat (3) @(negedge Clock);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
